// File: rtl/ricosoc_uart.sv
// rtl/ricosoc_uart.sv - iomem-bus 8N1 UART with baud divider, single-entry TX and buffered RX.
// Optional RICOSOC_UART_RXFIFO_EN: RX buffer becomes an RXFIFO_DEPTH-entry FIFO.
module ricosoc_uart #(
  parameter logic [31:0] BASE_ADDR    = 32'h0300_0000,
  parameter logic [15:0] CLKDIV_RESET = 16'd104,
  parameter int          RXFIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [15:0] clkdiv;
  logic [15:0] eff_period;
  logic [1:0]  tx_state, rx_state;
  logic [15:0] tx_cnt, tx_period, rx_cnt, rx_period;
  logic [7:0]  tx_shift, rx_shift;
  logic [2:0]  tx_bit, rx_bit;
  logic [2:0]  rx_sync;
  logic        rx_push, rx_ferr;
  logic        rx_overrun, frame_error;
  logic        rx_valid, rx_full, push_ok;
  logic [7:0]  rx_head;
  logic [3:0]  rx_fill;
  logic [31:0] read_mux;

  assign eff_period = (clkdiv < 16'd4) ? 16'd4 : clkdiv;

  wire       addr_hit  = iomem_addr[31:4] == BASE_ADDR[31:4];
  wire [1:0] reg_sel   = iomem_addr[3:2];
  wire       is_write  = |iomem_wstrb;
  wire       tx_busy   = tx_state != ST_IDLE;
  wire       req       = iomem_valid && addr_hit && !iomem_ready;
  // A DATA write is held off (no ready) until the transmitter is free again.
  wire       accept    = req && !(is_write && reg_sel == 2'd1 && tx_busy);
  wire       wr_clkdiv = accept && is_write && reg_sel == 2'd0;
  wire       wr_data   = accept && is_write && reg_sel == 2'd1;
  wire       wr_status = accept && is_write && reg_sel == 2'd2 && iomem_wstrb[0];
  wire       pop       = accept && !is_write && reg_sel == 2'd1 && rx_valid;
  wire       unused_ok = &{1'b0, iomem_addr[1:0], iomem_wdata[31:16], RXFIFO_DEPTH > 0};

  always_comb begin
    read_mux = 32'd0;
    case (reg_sel)
      2'd0: read_mux = {16'd0, clkdiv};
      2'd1: read_mux = rx_valid ? {24'd0, rx_head} : 32'hFFFF_FFFF;
      2'd2: read_mux = {24'd0, rx_fill, frame_error, rx_overrun, rx_valid, tx_busy};
      default: read_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'd0;
      clkdiv      <= CLKDIV_RESET;
      rx_overrun  <= 1'b0;
      frame_error <= 1'b0;
      irq         <= 1'b0;
    end else begin
      iomem_ready <= accept;
      iomem_rdata <= (accept && !is_write) ? read_mux : 32'd0;
      if (wr_clkdiv && iomem_wstrb[0]) clkdiv[7:0]  <= iomem_wdata[7:0];
      if (wr_clkdiv && iomem_wstrb[1]) clkdiv[15:8] <= iomem_wdata[15:8];
      if (rx_push && rx_full && !pop) rx_overrun <= 1'b1;
      else if (wr_status && iomem_wdata[2]) rx_overrun <= 1'b0;
      if (rx_ferr) frame_error <= 1'b1;
      else if (wr_status && iomem_wdata[3]) frame_error <= 1'b0;
      irq <= rx_valid;
    end
  end

  // Transmitter: period is latched at frame start so CLKDIV writes apply to the next frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_state  <= ST_IDLE;
      tx_cnt    <= 16'd0;
      tx_period <= 16'd4;
      tx_shift  <= 8'd0;
      tx_bit    <= 3'd0;
      uart_tx   <= 1'b1;
    end else if (tx_state == ST_IDLE) begin
      if (wr_data) begin
        tx_state  <= ST_START;
        uart_tx   <= 1'b0;
        tx_shift  <= iomem_wdata[7:0];
        tx_period <= eff_period;
        tx_cnt    <= eff_period - 16'd1;
      end
    end else if (tx_cnt != 16'd0) begin
      tx_cnt <= tx_cnt - 16'd1;
    end else begin
      tx_cnt <= tx_period - 16'd1;
      if (tx_state == ST_START) begin
        tx_state <= ST_DATA;
        tx_bit   <= 3'd0;
        uart_tx  <= tx_shift[0];
      end else if (tx_state == ST_DATA) begin
        if (tx_bit == 3'd7) begin
          tx_state <= ST_STOP;
          uart_tx  <= 1'b1;
        end else begin
          tx_bit   <= tx_bit + 3'd1;
          tx_shift <= {1'b0, tx_shift[7:1]};
          uart_tx  <= tx_shift[1];
        end
      end else begin
        tx_state <= ST_IDLE;
      end
    end
  end

  wire rx_s    = rx_sync[1];
  wire rx_prev = rx_sync[2];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_sync   <= 3'b111;
      rx_state  <= ST_IDLE;
      rx_cnt    <= 16'd0;
      rx_period <= 16'd4;
      rx_shift  <= 8'd0;
      rx_bit    <= 3'd0;
      rx_push   <= 1'b0;
      rx_ferr   <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[1:0], uart_rx};
      rx_push <= 1'b0;
      rx_ferr <= 1'b0;
      if (rx_state == ST_IDLE) begin
        if (rx_prev && !rx_s) begin
          rx_state  <= ST_START;
          rx_period <= eff_period;
          rx_cnt    <= (eff_period >> 1) - 16'd1;
        end
      end else if (rx_cnt != 16'd0) begin
        rx_cnt <= rx_cnt - 16'd1;
      end else begin
        rx_cnt <= rx_period - 16'd1;
        if (rx_state == ST_START) begin
          rx_state <= rx_s ? ST_IDLE : ST_DATA;
          rx_bit   <= 3'd0;
        end else if (rx_state == ST_DATA) begin
          rx_shift <= {rx_s, rx_shift[7:1]};
          rx_bit   <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state <= ST_STOP;
        end else begin
          rx_state <= ST_IDLE;
          rx_push  <= rx_s;
          rx_ferr  <= !rx_s;
        end
      end
    end
  end

  // A push into a full buffer still lands if the same cycle pops an entry.
  assign push_ok = rx_push && (!rx_full || pop);

`ifdef RICOSOC_UART_RXFIFO_EN
  localparam int PW = $clog2(RXFIFO_DEPTH);
  localparam int CW = $clog2(RXFIFO_DEPTH + 1);

  logic [7:0]    fifo_mem [RXFIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] rx_count;
  logic [31:0]   count_w;

  assign count_w  = 32'(rx_count);
  assign rx_valid = rx_count != '0;
  assign rx_full  = count_w == RXFIFO_DEPTH;
  assign rx_head  = fifo_mem[rd_ptr];
  assign rx_fill  = (count_w > 32'd15) ? 4'hF : count_w[3:0];

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      rx_count <= rx_count + CW'(push_ok) - CW'(pop);
    end
  end
`else
  logic [7:0] rx_hold;

  assign rx_valid = rx_full;
  assign rx_head  = rx_hold;
  assign rx_fill  = 4'd0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_full <= 1'b0;
      rx_hold <= 8'd0;
    end else begin
      if (push_ok) begin
        rx_full <= 1'b1;
        rx_hold <= rx_shift;
      end else if (pop) begin
        rx_full <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ricosoc_uart.sv
// tb/tb_ricosoc_uart.sv - directed self-checking bench for ricosoc_uart.
module tb_ricosoc_uart;

  localparam logic [31:0] BASE = 32'h0300_0000;
  localparam logic [31:0] A_CLKDIV = BASE + 32'h0;
  localparam logic [31:0] A_DATA   = BASE + 32'h4;
  localparam logic [31:0] A_STATUS = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'd0;
  logic [31:0] iomem_addr = 32'd0;
  logic [31:0] iomem_wdata = 32'd0;
  logic [31:0] iomem_rdata;
  logic        uart_tx;
  logic        uart_rx = 1'b1;
  logic        irq;

  int checks = 0;
  int errors = 0;

  ricosoc_uart dut (
    .clk(clk), .resetn(resetn),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .uart_tx(uart_tx), .uart_rx(uart_rx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] strb,
                          output logic [31:0] rd, output int lat);
    bit done;
    @(posedge clk); #1;
    iomem_valid = 1'b1; iomem_addr = a; iomem_wdata = wd; iomem_wstrb = strb;
    lat = 0; done = 0;
    while (!done && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (iomem_ready) done = 1;
    end
    rd = iomem_rdata;
    iomem_valid = 1'b0; iomem_wstrb = 4'd0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    int lat;
    bus_xfer(a, 32'd0, 4'd0, d, lat);
    check(tag, d, exp);
    check({tag, "_lat"}, lat, 1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] strb);
    logic [31:0] d;
    int lat;
    bus_xfer(a, wd, strb, d, lat);
    check("wr_lat", lat, 1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int per);
    @(posedge clk); #1;
    uart_rx = 1'b0;
    repeat (per) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (per) @(posedge clk);
      #1;
    end
    uart_rx = stop_bit;
    repeat (per) @(posedge clk);
    #1;
    uart_rx = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    logic [9:0]  frame;
    logic [7:0]  rx_bytes [5];
    int lat, lows;
    bit seen;

    rx_bytes[0] = 8'h11; rx_bytes[1] = 8'h22; rx_bytes[2] = 8'h33;
    rx_bytes[3] = 8'h44; rx_bytes[4] = 8'h55;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", uart_tx, 1);
    check("rst_irq", irq, 0);
    check("rst_ready", iomem_ready, 0);
    check("rst_rdata", iomem_rdata, 0);
    resetn = 1'b1;

    rd_chk("rd_clkdiv_rst", A_CLKDIV, 32'h0000_0068);
    rd_chk("rd_status_rst", A_STATUS, 32'h0);
    rd_chk("rd_data_empty", A_DATA, 32'hFFFF_FFFF);
    rd_chk("rd_reserved", BASE + 32'hC, 32'h0);
    wr(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);

    wr(A_CLKDIV, 32'hFFFF_0008, 4'h3);
    rd_chk("rd_clkdiv8", A_CLKDIV, 32'h8);

    frame = {1'b1, 8'hA5, 1'b0};
    wr(A_DATA, 32'hA5, 4'h1);
    fork
      begin
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
          check($sformatf("tx_bit%0d", i), uart_tx, frame[i]);
          repeat (8) @(posedge clk);
          #1;
        end
      end
      begin
        repeat (10) @(posedge clk);
        rd_chk("status_busy", A_STATUS, 32'h1);
        bus_xfer(A_DATA, 32'h5A, 4'h1, d, lat);
        check("data_wr_stall", (lat >= 55 && lat < 300) ? 32'd1 : 32'd0, 1);
      end
    join
    repeat (90) @(posedge clk);
    rd_chk("status_tx_done", A_STATUS, 32'h0);

    wr(A_CLKDIV, 32'h2, 4'h3);
    rd_chk("rd_clkdiv2", A_CLKDIV, 32'h2);
    wr(A_DATA, 32'h01, 4'h1);
    lows = 0; seen = 0;
    for (int k = 0; k < 20 && !(seen && uart_tx); k++) begin
      if (!uart_tx) begin
        lows++;
        seen = 1;
      end
      @(posedge clk); #1;
    end
    check("tx_min_period", lows, 4);
    repeat (60) @(posedge clk);

    wr(A_CLKDIV, 32'h10, 4'h3);
    send_rx(8'h3C, 1'b1, 16);
    repeat (3) @(posedge clk);
    #1;
    check("rx_irq_set", irq, 1);
`ifdef RICOSOC_UART_RXFIFO_EN
    rd_chk("rx_status_valid", A_STATUS, 32'h12);
`else
    rd_chk("rx_status_valid", A_STATUS, 32'h02);
`endif
    rd_chk("rx_data_3c", A_DATA, 32'h3C);
    repeat (2) @(posedge clk);
    #1;
    check("rx_irq_clr", irq, 0);

    send_rx(8'h55, 1'b0, 16);
    repeat (4) @(posedge clk);
    #1;
    check("ferr_irq", irq, 0);
    rd_chk("ferr_status", A_STATUS, 32'h8);
    wr(A_STATUS, 32'h8, 4'h1);
    rd_chk("ferr_cleared", A_STATUS, 32'h0);

    @(posedge clk); #1;
    uart_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("glitch_irq", irq, 0);
    rd_chk("glitch_status", A_STATUS, 32'h0);

    for (int i = 0; i < 5; i++) begin
      send_rx(rx_bytes[i], 1'b1, 16);
      repeat (16) @(posedge clk);
    end
`ifdef RICOSOC_UART_RXFIFO_EN
    rd_chk("ovr_status", A_STATUS, 32'h46);
    for (int i = 0; i < 4; i++)
      rd_chk($sformatf("fifo_rd%0d", i), A_DATA, {24'd0, rx_bytes[i]});
`else
    rd_chk("ovr_status", A_STATUS, 32'h06);
    rd_chk("hold_rd0", A_DATA, {24'd0, rx_bytes[0]});
`endif
    rd_chk("ovr_empty", A_DATA, 32'hFFFF_FFFF);
    rd_chk("ovr_sticky", A_STATUS, 32'h4);
    wr(A_STATUS, 32'h4, 4'h1);
    rd_chk("ovr_cleared", A_STATUS, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
